// File: rtl/l2_pkg.sv
// l2_pkg: shared sizing defaults and controller state encodings
package l2_pkg;
  localparam int L2_ADDR_W = 32;
  localparam int L2_DATA_W = 32;
  localparam int L2_INDEX_W = 8;
  localparam int L2_CNT_W = 32;
  localparam int TAG_W = L2_ADDR_W - L2_INDEX_W;
  localparam int LINES = 2 ** L2_INDEX_W;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_WB = 2'd2;
  localparam logic [1:0] S_FILL = 2'd3;
endpackage

// File: rtl/l2_cache_ctrl_if.sv
// l2_cache_ctrl_if: memory-side request/ack handshake between the L2 controller and main memory
interface l2_cache_ctrl_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic mem_req;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic mem_ack;
  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
  modport slave (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/l2_line_store.sv
// l2_line_store: tag/data arrays with valid/dirty flags, combinational read and synchronous write
module l2_line_store
  import l2_pkg::*;
#(
  parameter int IW = L2_INDEX_W,
  parameter int TW = TAG_W,
  parameter int DW = L2_DATA_W,
  parameter int N = LINES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [IW-1:0] idx,
  output logic [TW-1:0] rd_tag,
  output logic [DW-1:0] rd_data,
  output logic rd_valid,
  output logic rd_dirty,
  input  logic wr_en,
  input  logic [TW-1:0] wr_tag,
  input  logic [DW-1:0] wr_data,
  input  logic wr_dirty
);
  logic [TW-1:0] tag_mem [N];
  logic [DW-1:0] data_mem [N];
  logic [N-1:0] valid;
  logic [N-1:0] dirty;
  assign rd_tag = tag_mem[idx];
  assign rd_data = data_mem[idx];
  assign rd_valid = valid[idx];
  assign rd_dirty = dirty[idx];
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[idx] <= wr_tag;
      data_mem[idx] <= wr_data;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      dirty <= '0;
    end else if (wr_en) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= wr_dirty;
    end
  end
endmodule

// File: rtl/l2_cache_ctrl.sv
// l2_cache_ctrl: direct-mapped write-back write-allocate L2 controller with L1 stall handshake
module l2_cache_ctrl
  import l2_pkg::*;
#(
  parameter int ADDR_W = L2_ADDR_W,
  parameter int DATA_W = L2_DATA_W,
  parameter int INDEX_W = L2_INDEX_W,
  parameter int CNT_W = L2_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic [ADDR_W-1:0] addr,
  input  logic we,
  inout  wire  [DATA_W-1:0] data,
  output logic stall,
  l2_cache_ctrl_if.master mem,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] wb_cnt
);
  localparam int TW = ADDR_W - INDEX_W;
  logic [1:0] state;
  logic [ADDR_W-1:0] a_q;
  logic we_q;
  logic [DATA_W-1:0] wd_q;
  logic [DATA_W-1:0] rdata_q;
  logic [TW-1:0] rd_tag;
  logic [DATA_W-1:0] rd_data;
  logic rd_valid;
  logic rd_dirty;
  logic hit;
  logic victim_dirty;
  logic wr_en;
  logic [INDEX_W-1:0] idx;
  logic [TW-1:0] tag_q;
  assign idx = a_q[INDEX_W-1:0];
  assign tag_q = a_q[ADDR_W-1:INDEX_W];
  assign data = we ? rdata_q : 'z;
  always_comb begin
    hit = rd_valid && rd_tag == tag_q;
    victim_dirty = rd_valid && rd_dirty;
    wr_en = state == S_LOOKUP ? !we_q && (hit || !victim_dirty)
          : state == S_WB ? mem.mem_ack && !we_q
          : state == S_FILL ? mem.mem_ack : 1'b0;
  end
  l2_line_store #(.IW(INDEX_W), .TW(TW), .DW(DATA_W), .N(2 ** INDEX_W)) u_store (
    .clk(clk),
    .rst_n(rst_n),
    .idx(idx),
    .rd_tag(rd_tag),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .rd_dirty(rd_dirty),
    .wr_en(wr_en),
    .wr_tag(tag_q),
    .wr_data(state == S_FILL ? mem.mem_rdata : wd_q),
    .wr_dirty(state != S_FILL)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      stall <= 1'b0;
      mem.mem_req <= 1'b0;
      mem.mem_we <= 1'b0;
      mem.mem_addr <= '0;
      mem.mem_wdata <= '0;
      rdata_q <= '0;
      a_q <= '0;
      we_q <= 1'b1;
      wd_q <= '0;
      hit_cnt <= '0;
      miss_cnt <= '0;
      wb_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (req) begin
          a_q <= addr;
          we_q <= we;
          wd_q <= data;
          stall <= 1'b1;
          state <= S_LOOKUP;
        end
        S_LOOKUP: if (hit) begin
          if (!(&hit_cnt)) hit_cnt <= hit_cnt + 1'b1;
          if (we_q) rdata_q <= rd_data;
          stall <= 1'b0;
          state <= S_IDLE;
        end else begin
          if (!(&miss_cnt)) miss_cnt <= miss_cnt + 1'b1;
          if (victim_dirty) begin
            if (!(&wb_cnt)) wb_cnt <= wb_cnt + 1'b1;
            mem.mem_req <= 1'b1;
            mem.mem_we <= 1'b1;
            mem.mem_addr <= {rd_tag, idx};
            mem.mem_wdata <= rd_data;
            state <= S_WB;
          end else if (we_q) begin
            mem.mem_req <= 1'b1;
            mem.mem_we <= 1'b0;
            mem.mem_addr <= a_q;
            state <= S_FILL;
          end else begin
            stall <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_WB: if (mem.mem_ack) begin
          if (we_q) begin
            mem.mem_we <= 1'b0;
            mem.mem_addr <= a_q;
            state <= S_FILL;
          end else begin
            mem.mem_req <= 1'b0;
            stall <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: if (mem.mem_ack) begin
          rdata_q <= mem.mem_rdata;
          mem.mem_req <= 1'b0;
          stall <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_l2_cache_ctrl.sv
// tb_l2_cache_ctrl: directed checks of hit/miss/write-back paths against a 3-cycle memory model
module tb_l2_cache_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req = 1'b0;
  logic [31:0] addr = '0;
  logic we = 1'b1;
  logic [31:0] wdrv = '0;
  wire [31:0] data;
  logic stall;
  logic [31:0] hit_cnt, miss_cnt, wb_cnt;
  int checks = 0;
  int failures = 0;
  int rd_n = 0, wr_n = 0, cnt = 0;
  logic [31:0] last_rd_addr = '0, last_wr_addr = '0, last_wr_data = '0;
  logic [31:0] mem_arr [logic [31:0]];
  int n;
  logic [31:0] rd;
  l2_cache_ctrl_if #(.ADDR_W(32), .DATA_W(32)) mif ();
  assign data = we ? 'z : wdrv;
  l2_cache_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .we(we), .data(data),
    .stall(stall), .mem(mif), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
  );
  always #5 clk = ~clk;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mif.mem_ack = 1'b0;
      cnt = 0;
    end else begin
      if (mif.mem_ack) begin
        mif.mem_ack = 1'b0;
        cnt = 0;
      end
      if (mif.mem_req) begin
        cnt++;
        if (cnt == 3) begin
          mif.mem_ack = 1'b1;
          if (mif.mem_we) begin
            mem_arr[mif.mem_addr] = mif.mem_wdata;
            wr_n++;
            last_wr_addr = mif.mem_addr;
            last_wr_data = mif.mem_wdata;
          end else begin
            mif.mem_rdata = mem_arr.exists(mif.mem_addr) ? mem_arr[mif.mem_addr] : '0;
            rd_n++;
            last_rd_addr = mif.mem_addr;
          end
        end
      end
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // n counts clock edges from the request edge through the edge where stall falls
  task automatic access(input logic [31:0] a, input logic w, input logic [31:0] wd,
                        input logic glitch, output int edges, output logic [31:0] rdv);
    @(negedge clk);
    req = 1'b1; addr = a; we = w; wdrv = wd;
    @(negedge clk);
    req = 1'b0; we = 1'b1; addr = '0;
    check("stall_set", {31'd0, stall}, 32'd1);
    edges = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      req = 1'b0;
      if (!stall) break;
      if (glitch && i == 0) begin
        req = 1'b1;
        addr = 32'h55;
      end
    end
    check("stall_timeout", {31'd0, stall}, 32'd0);
    rdv = data;
  endtask
  initial begin
    mif.mem_ack = 1'b0;
    mif.mem_rdata = '0;
    mem_arr[32'h10] = 32'h12345678;
    mem_arr[32'h110] = 32'hBEEF0110;
    repeat (3) @(negedge clk);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_mem_req", {31'd0, mif.mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mif.mem_we}, 32'd0);
    check("rst_mem_addr", mif.mem_addr, 32'd0);
    check("rst_mem_wdata", mif.mem_wdata, 32'd0);
    check("rst_data", data, 32'd0);
    check("rst_cnts", hit_cnt | miss_cnt | wb_cnt, 32'd0);
    rst_n = 1'b1;
    access(32'h10, 1'b1, 32'h0, 1'b0, n, rd);
    check("miss_lat", n, 5);
    check("miss_data", rd, 32'h12345678);
    check("miss_cnt1", miss_cnt, 1);
    check("mem_rd1", rd_n, 1);
    check("mem_rd_addr1", last_rd_addr, 32'h10);
    access(32'h10, 1'b1, 32'h0, 1'b0, n, rd);
    check("hit_lat", n, 2);
    check("hit_data", rd, 32'h12345678);
    check("hit_cnt1", hit_cnt, 1);
    check("hit_no_mem", rd_n, 1);
    access(32'h10, 1'b0, 32'hAAAA0010, 1'b0, n, rd);
    check("whit_lat", n, 2);
    access(32'h10, 1'b1, 32'h0, 1'b0, n, rd);
    check("rd_after_w", rd, 32'hAAAA0010);
    check("hit_cnt3", hit_cnt, 3);
    check("no_mem_wr", wr_n, 0);
    access(32'h110, 1'b1, 32'h0, 1'b1, n, rd);
    check("dirty_lat", n, 8);
    check("dirty_data", rd, 32'hBEEF0110);
    check("wb_cnt1", wb_cnt, 1);
    check("wb_addr", last_wr_addr, 32'h10);
    check("wb_data", last_wr_data, 32'hAAAA0010);
    check("fill_addr", last_rd_addr, 32'h110);
    check("mem_rd2", rd_n, 2);
    check("glitch_total", hit_cnt + miss_cnt, 5);
    check("miss_cnt2", miss_cnt, 2);
    access(32'h33, 1'b0, 32'h0000CAFE, 1'b0, n, rd);
    check("wmiss_lat", n, 2);
    check("wmiss_cnt", miss_cnt, 3);
    check("wmiss_no_mem", rd_n + wr_n, 3);
    access(32'h33, 1'b1, 32'h0, 1'b0, n, rd);
    check("wmiss_rd", rd, 32'h0000CAFE);
    access(32'h133, 1'b0, 32'h00001234, 1'b0, n, rd);
    check("wdirty_lat", n, 5);
    check("wdirty_wb", wb_cnt, 2);
    check("wdirty_wb_data", last_wr_data, 32'h0000CAFE);
    check("wdirty_wb_addr", last_wr_addr, 32'h33);
    access(32'h133, 1'b1, 32'h0, 1'b0, n, rd);
    check("wdirty_rd", rd, 32'h00001234);
    check("hit_cnt5", hit_cnt, 5);
    check("miss_cnt4", miss_cnt, 4);
    @(negedge clk);
    req = 1'b1; addr = 32'h44;
    @(negedge clk);
    req = 1'b0; addr = '0;
    for (int i = 0; i < 10 && !mif.mem_req; i++) @(negedge clk);
    check("fill_started", {31'd0, mif.mem_req}, 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_stall", {31'd0, stall}, 32'd0);
    check("async_mem_req", {31'd0, mif.mem_req}, 32'd0);
    check("async_mem_addr", mif.mem_addr, 32'd0);
    check("async_cnts", hit_cnt | miss_cnt | wb_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    access(32'h10, 1'b1, 32'h0, 1'b0, n, rd);
    check("post_rst_lat", n, 5);
    check("post_rst_data", rd, 32'hAAAA0010);
    check("post_rst_miss", miss_cnt, 1);
    check("post_rst_hit", hit_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
